// File: rtl/dma_cmd_sched.sv
// Two-requester DMA command scheduler: round-robin grant, MAX_CHUNK splitting, per-chunk timeout, one completion per request.
// Grant->dma_start >=1 cycle, dma_done->next start/cpl 1 cycle; req_ready only in IDLE, ISSUE stalls on host_ready_for_cmd.
module dma_cmd_sched #(
    parameter int unsigned MAX_CHUNK = 256,
    parameter int unsigned TO_CYCLES = 1048576
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [1:0]  req_val,
    output logic [1:0]  req_ready,
    input  logic [24:0] req0_addr,
    input  logic [24:0] req1_addr,
    input  logic [31:0] req0_lba,
    input  logic [31:0] req1_lba,
    input  logic [31:0] req0_cnt,
    input  logic [31:0] req1_cnt,
    input  logic        req0_type,
    input  logic        req1_type,
    input  logic        host_ready_for_cmd,
    output logic [24:0] mem_address,
    output logic [31:0] lba,
    output logic [31:0] sector_cnt,
    output logic        dma_type,
    output logic        dma_start,
    input  logic        dma_done,
    output logic        cpl_val,
    output logic        cpl_id,
    output logic        cpl_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CPL   = 2'd3;

    localparam int unsigned TW = $clog2(TO_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
    localparam logic [31:0] MAXC = 32'(MAX_CHUNK);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic          err_q, err_d;
    logic          type_q, type_d;
    logic [24:0]   addr_q, addr_d;
    logic [31:0]   lba_q, lba_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          gnt_id;
    logic [31:0]   gnt_cnt, gnt_chunk, nxt_rem, nxt_chunk;

    // On a tie the requester that did not win last time gets the grant.
    assign gnt_id    = (req_val == 2'b11) ? ~last_q : req_val[1];
    assign gnt_cnt   = gnt_id ? req1_cnt : req0_cnt;
    assign gnt_chunk = (gnt_cnt > MAXC) ? MAXC : gnt_cnt;
    assign nxt_rem   = rem_q - cnt_q;
    assign nxt_chunk = (nxt_rem > MAXC) ? MAXC : nxt_rem;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        err_d   = err_q;
        type_d  = type_q;
        addr_d  = addr_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (|req_val) begin
                    id_d  = gnt_id;
                    err_d = 1'b0;
                    rem_d = gnt_cnt;
                    if (gnt_cnt == 32'd0) begin
                        state_d = S_CPL;
                    end else begin
                        // Engine-facing fields only change on entry to ISSUE.
                        type_d  = gnt_id ? req1_type : req0_type;
                        addr_d  = gnt_id ? req1_addr : req0_addr;
                        lba_d   = gnt_id ? req1_lba  : req0_lba;
                        cnt_d   = gnt_chunk;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (host_ready_for_cmd) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dma_done) begin
                    rem_d = nxt_rem;
                    if (nxt_rem == 32'd0) begin
                        state_d = S_CPL;
                    end else begin
                        addr_d  = addr_q + {cnt_q[22:0], 2'b00};
                        lba_d   = lba_q + cnt_q;
                        cnt_d   = nxt_chunk;
                        state_d = S_ISSUE;
                    end
                end else if (tmo_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_CPL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                last_d  = id_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= 1'b0;
            addr_q  <= '0;
            lba_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
        end
    end

    // Strobes are masked while rst is high so nothing leaks out in the reset cycle.
    assign req_ready   = (state_q == S_IDLE && !rst && |req_val) ?
                         (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign dma_start   = (state_q == S_ISSUE) && host_ready_for_cmd && !rst;
    assign cpl_val     = (state_q == S_CPL) && !rst;
    assign cpl_id      = cpl_val & id_q;
    assign cpl_err     = cpl_val & err_q;
    assign busy        = (state_q != S_IDLE);
    assign mem_address = addr_q;
    assign lba         = lba_q;
    assign sector_cnt  = cnt_q;
    assign dma_type    = type_q;

endmodule
